// File: rtl/ray_dir_gen_pkg.sv
// ray_dir_gen_pkg
// Shared definitions for the primary-ray direction generator: the 27-bit
// float layout (sign | 8-bit exponent, bias 127 | 18-bit mantissa) and a
// field-packing helper used by the integer-to-float converter.
package ray_dir_gen_pkg;

  localparam int FP_W        = 27;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 18;
  localparam int FP_EXP_BIAS = 127;
  localparam int FP_SIGN_POS = 26;
  localparam int FP_EXP_HI   = 25;
  localparam int FP_EXP_LO   = 18;
  localparam int FP_MAN_HI   = 17;

  localparam logic [FP_W-1:0] FP_ONE = 27'h1FC0000;

  typedef logic [FP_W-1:0] fp_t;

  function automatic fp_t fp_pack(input logic                sign,
                                  input logic [FP_EXP_W-1:0] exp_f,
                                  input logic [FP_MAN_W-1:0] man_f);
    fp_t f;
    f = '0;
    f[FP_SIGN_POS]         = sign;
    f[FP_EXP_HI:FP_EXP_LO] = exp_f;
    f[FP_MAN_HI:0]         = man_f;
    return f;
  endfunction

endpackage

// File: rtl/ray_dir_gen_int_to_fp.sv
// ray_dir_gen_int_to_fp
// Combinational signed integer to 27-bit float conversion. Exact: the
// operand never has more significant bits than the mantissa can hold, so no
// rounding is needed. Zero converts to all-zero.
// Ports:
//   value   in   IN_W  signed integer operand
//   result  out  27    float encoding of value
module ray_dir_gen_int_to_fp
  import ray_dir_gen_pkg::*;
#(
  parameter int IN_W = 12
) (
  input  logic signed [IN_W-1:0] value,
  output fp_t                    result
);

  localparam int LEAD_W = $clog2(IN_W);

  logic [IN_W-1:0]     mag;
  logic [LEAD_W-1:0]   lead;
  logic [FP_MAN_W-1:0] man;

  always_comb begin
    mag  = value[IN_W-1] ? -value : value;
    lead = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (mag[i]) lead = LEAD_W'(i);
    end
    // Shifting right by the leading-one position parks the leading one just
    // above the mantissa field; the truncation drops it and everything above.
    man = FP_MAN_W'({mag, {FP_MAN_W{1'b0}}} >> lead);
    if (mag == '0) result = '0;
    else result = fp_pack(value[IN_W-1],
                          FP_EXP_W'(FP_EXP_BIAS) + FP_EXP_W'(lead), man);
  end

endmodule

// File: rtl/ray_dir_gen.sv
// ray_dir_gen
// Raster-order primary-ray direction generator. Walks every pixel of the
// frame and emits the unnormalized camera-space direction
// (2*px-(H_RES-1), (V_RES-1)-2*py, FOCAL) as 27-bit floats under a
// valid/ready handshake.
// Ports:
//   i_clk         in   1   clock, rising edge
//   i_rst_n       in   1   synchronous active-low reset
//   i_start       in   1   begin a frame (honoured in IDLE only)
//   i_ready       in   1   downstream accepts the current ray
//   o_valid       out  1   ray outputs valid
//   o_pixel_x/y   out  -   pixel coordinates of current ray
//   o_dir_x/y/z   out  27  direction components
//   o_busy        out  1   frame in progress
//   o_frame_done  out  1   one-cycle pulse after the last ray transfers
//
// state | meaning
// IDLE  | no frame in progress, waiting for i_start
// RUN   | presenting rays, advancing on every transfer
module ray_dir_gen
  import ray_dir_gen_pkg::*;
#(
  parameter int  H_RES = 640,
  parameter int  V_RES = 480,
  parameter fp_t FOCAL = FP_ONE
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [$clog2(H_RES)-1:0] o_pixel_x,
  output logic [$clog2(V_RES)-1:0] o_pixel_y,
  output fp_t                      o_dir_x,
  output fp_t                      o_dir_y,
  output fp_t                      o_dir_z,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int PX_W = $clog2(H_RES);
  localparam int PY_W = $clog2(V_RES);
  localparam int X_W  = PX_W + 2;
  localparam int Y_W  = PY_W + 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_nxt;
  logic [PX_W-1:0]  px_q, px_nxt;
  logic [PY_W-1:0]  py_q, py_nxt;
  logic             load;
  logic             done_nxt;
  logic signed [X_W-1:0] x_int;
  logic signed [Y_W-1:0] y_int;
  fp_t              x_fp, y_fp;

  always_comb begin
    state_nxt = state_q;
    px_nxt    = px_q;
    py_nxt    = py_q;
    load      = 1'b0;
    done_nxt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_RUN;
          px_nxt    = '0;
          py_nxt    = '0;
          load      = 1'b1;
        end
      end
      default: begin
        if (i_ready) begin
          if (px_q == PX_W'(H_RES - 1)) begin
            px_nxt = '0;
            if (py_q == PY_W'(V_RES - 1)) begin
              // Last ray taken: direction registers keep the final ray.
              state_nxt = ST_IDLE;
              py_nxt    = '0;
              done_nxt  = 1'b1;
            end else begin
              py_nxt = py_q + PY_W'(1);
              load   = 1'b1;
            end
          end else begin
            px_nxt = px_q + PX_W'(1);
            load   = 1'b1;
          end
        end
      end
    endcase
  end

  // Both operands are odd for even resolutions, so they are never zero.
  assign x_int = $signed({1'b0, px_nxt, 1'b0}) - X_W'(H_RES - 1);
  assign y_int = Y_W'(V_RES - 1) - $signed({1'b0, py_nxt, 1'b0});

  ray_dir_gen_int_to_fp #(.IN_W(X_W)) u_cvt_x (.value(x_int), .result(x_fp));
  ray_dir_gen_int_to_fp #(.IN_W(Y_W)) u_cvt_y (.value(y_int), .result(y_fp));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      px_q         <= '0;
      py_q         <= '0;
      o_dir_x      <= '0;
      o_dir_y      <= '0;
      o_dir_z      <= '0;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      px_q         <= px_nxt;
      py_q         <= py_nxt;
      o_frame_done <= done_nxt;
      if (load) begin
        o_dir_x <= x_fp;
        o_dir_y <= y_fp;
        o_dir_z <= FOCAL;
      end
    end
  end

  assign o_valid   = (state_q == ST_RUN);
  assign o_busy    = (state_q == ST_RUN);
  assign o_pixel_x = px_q;
  assign o_pixel_y = py_q;

endmodule

// File: tb/tb_ray_dir_gen.sv
module tb_ray_dir_gen;
  localparam int SH = 8;
  localparam int SV = 4;
  localparam int SN = SH * SV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passes++;
  endtask

  // Reference conversion from the number-format definition.
  function automatic logic [26:0] fp_of(input int v);
    int s, m, p, man;
    if (v == 0) return 27'h0;
    s = (v < 0) ? 1 : 0;
    m = (v < 0) ? -v : v;
    p = 0;
    while ((1 << (p + 1)) <= m) p++;
    man = (m - (1 << p)) << (18 - p);
    return {s[0], 8'(127 + p), 18'(man)};
  endfunction

  // ---------------- small DUT (8x4), fully modelled ----------------
  logic rst_n_s = 1'b0, start_s = 1'b0, ready_s = 1'b0;
  logic v_s, busy_s, done_s;
  logic [2:0] px_s;
  logic [1:0] py_s;
  logic [26:0] dx_s, dy_s, dz_s;

  ray_dir_gen #(.H_RES(SH), .V_RES(SV)) dut (
    .i_clk(clk), .i_rst_n(rst_n_s), .i_start(start_s), .i_ready(ready_s),
    .o_valid(v_s), .o_pixel_x(px_s), .o_pixel_y(py_s),
    .o_dir_x(dx_s), .o_dir_y(dy_s), .o_dir_z(dz_s),
    .o_busy(busy_s), .o_frame_done(done_s));

  // ---------------- big DUT (640x480), literal spot checks ----------------
  logic rst_n_b = 1'b0, start_b = 1'b0, ready_b = 1'b1;
  logic v_b, busy_b, done_b;
  logic [9:0] px_b;
  logic [8:0] py_b;
  logic [26:0] dx_b, dy_b, dz_b;

  ray_dir_gen #(.H_RES(640), .V_RES(480)) dut_big (
    .i_clk(clk), .i_rst_n(rst_n_b), .i_start(start_b), .i_ready(ready_b),
    .o_valid(v_b), .o_pixel_x(px_b), .o_pixel_y(py_b),
    .o_dir_x(dx_b), .o_dir_y(dy_b), .o_dir_z(dz_b),
    .o_busy(busy_b), .o_frame_done(done_b));

  // Behavioural model of the small DUT: frame position as a linear index.
  bit m_act = 0, m_done = 0, m_clean = 1, chk_en = 0;
  int m_idx = 0;
  int xfer_cnt = 0;
  int seen [SN];

  always @(posedge clk) begin
    if (v_s === 1'b1 && ready_s) begin
      xfer_cnt++;
      seen[py_s * SH + px_s]++;
    end
    if (!rst_n_s) begin
      m_act = 0; m_done = 0; m_idx = 0; m_clean = 1;
    end else if (m_act) begin
      m_done = 0;
      if (ready_s) begin
        if (m_idx == SN - 1) begin
          m_act = 0; m_done = 1; m_idx = 0;
        end else m_idx++;
      end
    end else begin
      m_done = 0;
      if (start_s) begin
        m_act = 1; m_idx = 0; m_clean = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", v_s, m_act);
      chk("busy", busy_s, m_act);
      chk("frame_done", done_s, m_done);
      if (m_act) begin
        chk("pixel_x", px_s, m_idx % SH);
        chk("pixel_y", py_s, m_idx / SH);
        chk("dir_x", dx_s, fp_of(2 * (m_idx % SH) - (SH - 1)));
        chk("dir_y", dy_s, fp_of((SV - 1) - 2 * (m_idx / SH)));
        chk("dir_z", dz_s, 27'h1FC0000);
      end else if (m_clean) begin
        chk("idle_zero", {px_s, py_s, dx_s, dy_s, dz_s} == '0, 1);
      end
    end
  end

  int cnt, bad;

  initial begin
    foreach (seen[i]) seen[i] = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    // Reset state, both DUTs.
    chk("rst_valid_b", v_b, 0);
    chk("rst_zero_b", {px_b, py_b, dx_b, dy_b, dz_b, busy_b, done_b} == '0, 1);
    rst_n_s = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);

    // ---- big DUT: first ray, mid-row, row wrap, mid-frame reset ----
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    chk("big_first_valid", v_b, 1);
    chk("big_first_busy", busy_b, 1);
    chk("big_first_px", px_b, 0);
    chk("big_first_py", py_b, 0);
    chk("big_first_dx", dx_b, 27'h620FE00);
    chk("big_first_dy", dy_b, 27'h21F7C00);
    chk("big_first_dz", dz_b, 27'h1FC0000);
    repeat (320) @(negedge clk);
    chk("big_px320", px_b, 320);
    chk("big_dx320", dx_b, 27'h1FC0000);
    repeat (319) @(negedge clk);
    chk("big_px639", px_b, 639);
    chk("big_dx639", dx_b, 27'h220FE00);
    @(negedge clk);
    chk("big_wrap_valid", v_b, 1);
    chk("big_wrap_px", px_b, 0);
    chk("big_wrap_py", py_b, 1);
    chk("big_wrap_dy", dy_b, 27'h21F7400);
    chk("big_wrap_dx", dx_b, 27'h620FE00);
    repeat (5) @(negedge clk);
    rst_n_b = 1'b0;
    @(negedge clk);
    chk("big_rst_zero", {v_b, busy_b, done_b, px_b, py_b, dx_b, dy_b, dz_b} == '0, 1);
    rst_n_b = 1'b1;
    @(negedge clk);
    chk("big_rst_no_done", done_b, 0);
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    chk("big_restart_px", {px_b, py_b}, 0);
    chk("big_restart_dy", dy_b, 27'h21F7C00);
    rst_n_b = 1'b0;

    // ---- small DUT frame 1: ready held high, start pulsed mid-run ----
    ready_s = 1'b1;
    xfer_cnt = 0;
    start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    chk("s_first_dx", dx_s, 27'h6070000);
    chk("s_first_dy", dy_s, 27'h2020000);
    cnt = 1;
    while (!done_s && cnt < 200) begin
      @(negedge clk); cnt++;
      if (cnt == 10) start_s = 1'b1;
      if (cnt == 11) start_s = 1'b0;
      if (cnt == 32) begin
        chk("s_last_px", px_s, 7);
        chk("s_last_py", py_s, 3);
        chk("s_last_dx", dx_s, 27'h2070000);
        chk("s_last_dy", dy_s, 27'h6020000);
      end
    end
    chk("s_frame_cycles", cnt, 33);
    chk("s_frame_xfers", xfer_cnt, SN);
    chk("s_done_valid_low", v_s, 0);

    // ---- restart during the frame_done cycle, then random stalls ----
    xfer_cnt = 0;
    foreach (seen[i]) seen[i] = 0;
    start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    chk("s_restart_valid", v_s, 1);
    chk("s_restart_pix", {px_s, py_s}, 0);
    chk("s_restart_no_done", done_s, 0);
    cnt = 0;
    while (!done_s && cnt < 1000) begin
      ready_s = 1'($urandom_range(0, 1));
      @(negedge clk); cnt++;
    end
    chk("s_stall_finished", done_s, 1);
    chk("s_stall_xfers", xfer_cnt, SN);
    bad = 0;
    foreach (seen[i]) if (seen[i] != 1) bad++;
    chk("s_scoreboard_once", bad, 0);
    ready_s = 1'b1;

    // ---- mid-frame reset, then restart ----
    repeat (2) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    repeat (13) @(negedge clk);
    rst_n_s = 1'b0;
    @(negedge clk);
    chk("s_rst_zero", {v_s, busy_s, done_s, px_s, py_s, dx_s, dy_s, dz_s} == '0, 1);
    rst_n_s = 1'b1;
    repeat (3) @(negedge clk);
    chk("s_rst_no_done", done_s, 0);
    start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    chk("s_rst_restart_pix", {px_s, py_s}, 0);
    chk("s_rst_restart_dx", dx_s, 27'h6070000);
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
